mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: MEM_BYTES, default 128, size of the memory_block byte array; the range-check limit.
REQ-002 Parameter: WAIT_CYCLES, default 1 (legal 1-15), number of cycles memory strobes are held per access.
REQ-003 Clocking: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  CPU request present.
REQ-007 req_ready  out  1  unit can accept a request (IDLE only).
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_byte  in  1  1 = byte access, 0 = 32-bit word access.
REQ-010 req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
REQ-011 req_addr  in  18  byte address.
REQ-012 req_wdata  in  32  store data; byte stores use [7:0].
REQ-013 resp_valid  out  1  response present.
REQ-014 resp_ready  in  1  CPU accepts response.
REQ-015 resp_rdata  out  32  load result; 0 for stores and errors.
REQ-016 resp_err  out  1  access rejected as out of range.
REQ-017 memRead  out  1  read strobe to memory_block.
REQ-018 memWrite  out  1  write strobe to memory_block.
REQ-019 byteOperations  out  1  byte-mode select to memory_block.
REQ-020 address  out  18  memory byte address.
REQ-021 write_data  out  32  memory write data.
REQ-022 read_data  in  32  memory read data (combinational from memory_block).

Function
REQ-023 FSM states IDLE, ACCESS, RESP, ERR; req_ready = 1 only in IDLE.
REQ-024 IDLE: on req_valid=1, latch req_write/byte/signed/addr/wdata; range check in 19 bits: byte fails if addr >= MEM_BYTES, word fails if addr+3 >= MEM_BYTES.
REQ-025 IDLE transitions: check passes -> ACCESS; check fails -> ERR; req_valid=0 -> stay IDLE.
REQ-026 ACCESS: memRead = ~write, memWrite = write, byteOperations/address/write_data = latched values, all registered and stable for exactly WAIT_CYCLES cycles.
REQ-027 ACCESS: 4-bit wait counter cleared on entry; leaves to RESP at the edge ending the WAIT_CYCLES-th cycle; loads capture read_data at that edge.
REQ-028 Load result: word -> read_data[31:0]; byte -> read_data[7:0] extended to 32 bits per req_signed; store result -> 0.
REQ-029 memRead and memWrite never both 1; both 0 outside ACCESS; address/write_data hold last values outside ACCESS.
REQ-030 RESP: resp_valid=1, resp_err=0, resp_rdata stable; resp_ready=1 -> IDLE at that edge.
REQ-031 ERR: resp_valid=1, resp_err=1, resp_rdata=0, no memory strobes; resp_ready=1 -> IDLE.
REQ-032 Latency: request accepted at edge N -> strobes high cycles N+1..N+WAIT_CYCLES -> resp_valid high from cycle N+WAIT_CYCLES+1; error response from cycle N+1.
REQ-033 resp_ready while resp_valid=0 is ignored; req_valid outside IDLE is ignored, not queued.
REQ-034 Back-to-back: after resp handshake at edge M, a new request is accepted no earlier than edge M+1.

Reset
REQ-035 reset=1 at an edge: state IDLE, counter 0, memRead=memWrite=byteOperations=0, address=0, write_data=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=1 the following cycle.
REQ-036 Reset mid-ACCESS deasserts strobes at that edge; the in-flight access produces no response.

Verification
REQ-037 Word store addr=0x10, wdata=0xDEADBEEF, WAIT_CYCLES=1 -> memWrite=1 one cycle, byteOperations=0, address=0x10; resp_valid next cycle, resp_rdata=0, resp_err=0.
REQ-038 Word load addr=0x10 after REQ-037 -> memRead=1 one cycle; resp_rdata=0xDEADBEEF.
REQ-039 Byte load addr=0x13 (byte 0xDE), req_signed=1 -> 0xFFFFFFDE; req_signed=0 -> 0x000000DE.
REQ-040 Word load addr=125 (MEM_BYTES=128) -> resp_err=1, resp_rdata=0, no strobe; byte load addr=127 -> accepted; byte addr=128 -> error.
REQ-041 resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, new req_valid ignored; WAIT_CYCLES=3 -> strobes high exactly 3 cycles.
REQ-042 reset asserted during ACCESS -> strobes 0 next cycle, no resp_valid, req_ready=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU-facing load/store unit in front of a byte-addressed
// memory_block. Checks the range of each request, drives registered memory
// strobes for WAIT_CYCLES cycles, then returns one response.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both 1. req_ready is 1 only in IDLE. A request
// presented in any other state is ignored, not queued. resp_valid stays high,
// with resp_rdata and resp_err stable, until the edge where resp_ready is 1.
// resp_ready has no effect while resp_valid is 0.
module mem_access_unit #(
  parameter int MEM_BYTES   = 128,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic        req_signed,
  input  logic [17:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        memRead,
  output logic        memWrite,
  output logic        byteOperations,
  output logic [17:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  localparam logic [18:0] LIMIT     = 19'(MEM_BYTES);
  localparam logic [3:0]  LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic        lat_byte;
  logic        lat_signed;
  logic [18:0] last_byte;
  logic        in_range;
  logic        wait_done;

  // Highest byte the request touches, computed in 19 bits so that addresses
  // near the top of the 18-bit space cannot wrap back into range.
  always_comb begin
    last_byte = {1'b0, req_addr} + (req_byte ? 19'd0 : 19'd3);
    in_range  = (last_byte < LIMIT);
    wait_done = (wait_cnt == LAST_WAIT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and the state-decoded handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = in_range ? ACCESS : ERR;
      end
      ACCESS: begin
        if (wait_done) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      ERR: begin
        resp_valid = 1'b1;
        resp_err   = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

  // Request latch, registered memory strobes, wait counter and load capture.
  // address/write_data are loaded only for accepted in-range requests, so they
  // hold their last values outside ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt       <= 4'd0;
      lat_write      <= 1'b0;
      lat_byte       <= 1'b0;
      lat_signed     <= 1'b0;
      memRead        <= 1'b0;
      memWrite       <= 1'b0;
      byteOperations <= 1'b0;
      address        <= 18'd0;
      write_data     <= 32'd0;
      resp_rdata     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_byte   <= req_byte;
            lat_signed <= req_signed;
            wait_cnt   <= 4'd0;
            resp_rdata <= 32'd0;
            if (in_range) begin
              memRead        <= ~req_write;
              memWrite       <= req_write;
              byteOperations <= req_byte;
              address        <= req_addr;
              write_data     <= req_wdata;
            end
          end
        end
        ACCESS: begin
          if (wait_done) begin
            memRead        <= 1'b0;
            memWrite       <= 1'b0;
            byteOperations <= 1'b0;
            if (lat_write)     resp_rdata <= 32'd0;
            else if (lat_byte) resp_rdata <= {{24{lat_signed & read_data[7]}}, read_data[7:0]};
            else               resp_rdata <= read_data;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: two instances (WAIT_CYCLES=1 and 3), each
// with its own byte-array memory model, driven by directed requests whose
// expected results are worked out by hand.
module tb_mem_access_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  // shared request fields, per-instance valid/ready
  logic        req_write, req_byte, req_signed;
  logic [17:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_valid_a, req_valid_b, resp_ready_a, resp_ready_b;

  logic        req_ready_a, resp_valid_a, resp_err_a, mem_read_a, mem_write_a, byte_ops_a;
  logic [17:0] address_a;
  logic [31:0] write_data_a, resp_rdata_a, read_data_a;
  logic [1:0]  state_a;

  logic        req_ready_b, resp_valid_b, resp_err_b, mem_read_b, mem_write_b, byte_ops_b;
  logic [17:0] address_b;
  logic [31:0] write_data_b, resp_rdata_b, read_data_b;
  logic [1:0]  state_b;

  mem_access_unit #(.MEM_BYTES(128), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(rst_a),
    .req_valid(req_valid_a), .req_ready(req_ready_a),
    .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready_a),
    .resp_rdata(resp_rdata_a), .resp_err(resp_err_a),
    .memRead(mem_read_a), .memWrite(mem_write_a), .byteOperations(byte_ops_a),
    .address(address_a), .write_data(write_data_a), .read_data(read_data_a),
    .dbg_state(state_a)
  );

  mem_access_unit #(.MEM_BYTES(128), .WAIT_CYCLES(3)) dut_b (
    .clk(clk), .reset(rst_b),
    .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_write(req_write), .req_byte(req_byte), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
    .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .memRead(mem_read_b), .memWrite(mem_write_b), .byteOperations(byte_ops_b),
    .address(address_b), .write_data(write_data_b), .read_data(read_data_b),
    .dbg_state(state_b)
  );

  // ---------------- memory models (little-endian byte arrays) ----------------
  logic [7:0] mem_a [0:127];
  logic [7:0] mem_b [0:127];

  always @(posedge clk) begin
    if (mem_write_a) begin
      if (byte_ops_a) mem_a[address_a[6:0]] <= write_data_a[7:0];
      else for (int i = 0; i < 4; i++) mem_a[address_a[6:0] + 7'(i)] <= write_data_a[8*i +: 8];
    end
    if (mem_write_b) begin
      if (byte_ops_b) mem_b[address_b[6:0]] <= write_data_b[7:0];
      else for (int i = 0; i < 4; i++) mem_b[address_b[6:0] + 7'(i)] <= write_data_b[8*i +: 8];
    end
  end

  // Full word is always returned; bytes beyond the array read as 8'hA5 so a
  // byte load that leaks the upper bytes shows up.
  always_comb begin
    read_data_a = 32'd0;
    read_data_b = 32'd0;
    for (int i = 0; i < 4; i++) begin
      logic [18:0] ia, ib;
      ia = {1'b0, address_a} + 19'(i);
      ib = {1'b0, address_b} + 19'(i);
      read_data_a[8*i +: 8] = (ia < 19'd128) ? mem_a[ia[6:0]] : 8'hA5;
      read_data_b[8*i +: 8] = (ib < 19'd128) ? mem_b[ib[6:0]] : 8'hA5;
    end
  end

  // ---------------- instance selection for observation ----------------
  bit          sel_b;
  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_read, o_mem_write, o_byte_ops;
  logic [17:0] o_address;
  logic [31:0] o_write_data, o_resp_rdata;
  logic [1:0]  o_state;

  always_comb begin
    o_req_ready  = sel_b ? req_ready_b  : req_ready_a;
    o_resp_valid = sel_b ? resp_valid_b : resp_valid_a;
    o_resp_err   = sel_b ? resp_err_b   : resp_err_a;
    o_mem_read   = sel_b ? mem_read_b   : mem_read_a;
    o_mem_write  = sel_b ? mem_write_b  : mem_write_a;
    o_byte_ops   = sel_b ? byte_ops_b   : byte_ops_a;
    o_address    = sel_b ? address_b    : address_a;
    o_write_data = sel_b ? write_data_b : write_data_a;
    o_resp_rdata = sel_b ? resp_rdata_b : resp_rdata_a;
    o_state      = sel_b ? state_b      : state_a;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut_%s): got %h expected %h", tag, sel_b ? "b" : "a", act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_valid(input logic v);
    if (sel_b) req_valid_b = v; else req_valid_a = v;
  endtask

  task automatic set_rready(input logic v);
    if (sel_b) resp_ready_b = v; else resp_ready_a = v;
  endtask

  task automatic set_rst(input logic v);
    if (sel_b) rst_b = v; else rst_a = v;
  endtask

  task automatic present(input logic w, input logic b, input logic s,
                         input logic [17:0] a, input logic [31:0] wd);
    req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd;
    set_valid(1'b1);
  endtask

  // One full transaction: issue, follow the strobes, check the response,
  // optionally stall the response (with ignored requests), then handshake.
  task automatic do_req(input logic w, input logic b, input logic s,
                        input logic [17:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int stall);
    int wait_n, strobes, k;
    logic [31:0] exp_v;
    wait_n = sel_b ? 3 : 1;
    exp_q.push_back(exp_rd);
    @(negedge clk);
    check("req_ready_idle", o_req_ready, 1'b1);
    present(w, b, s, a, wd);
    @(negedge clk);
    set_valid(1'b0);
    strobes = 0;
    k = 1;
    while (!o_resp_valid && k <= 20) begin
      if (o_mem_read || o_mem_write) begin
        strobes++;
        check("strobe_excl", 32'(o_mem_read & o_mem_write), 32'd0);
        check("strobe_dir", 32'(o_mem_write), 32'(w));
        check("strobe_addr", 32'(o_address), 32'(a));
        check("strobe_byte", 32'(o_byte_ops), 32'(b));
        if (w) check("strobe_wdata", o_write_data, wd);
      end
      @(negedge clk);
      k++;
    end
    check("resp_valid", 32'(o_resp_valid), 32'd1);
    check("latency", 32'(k), exp_err ? 32'd1 : 32'(wait_n + 1));
    check("strobe_cycles", 32'(strobes), exp_err ? 32'd0 : 32'(wait_n));
    check("resp_err", 32'(o_resp_err), 32'(exp_err));
    exp_v = exp_q.pop_front();
    check("resp_rdata", o_resp_rdata, exp_v);
    check("req_ready_busy", 32'(o_req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      present(1'b1, 1'b0, 1'b0, 18'h20, 32'h0BADF00D);
      @(negedge clk);
      check("stall_valid", 32'(o_resp_valid), 32'd1);
      check("stall_rdata", o_resp_rdata, exp_v);
      check("stall_ready", 32'(o_req_ready), 32'd0);
      check("stall_strobe", 32'(o_mem_read | o_mem_write), 32'd0);
    end
    set_valid(1'b0);
    set_rready(1'b1);
    @(negedge clk);
    set_rready(1'b0);
    check("post_hs_valid", 32'(o_resp_valid), 32'd0);
    check("post_hs_ready", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    check("post_hs_idle", 32'(o_state), 32'd0);
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst_resp_err", 32'(o_resp_err), 32'd0);
    check("rst_strobes", 32'({o_mem_read, o_mem_write, o_byte_ops}), 32'd0);
    check("rst_address", 32'(o_address), 32'd0);
    check("rst_write_data", o_write_data, 32'd0);
    check("rst_rdata", o_resp_rdata, 32'd0);
    check("rst_state", 32'(o_state), 32'd0);
  endtask

  // Reset asserted while the strobes are high: strobes drop, no response.
  task automatic reset_mid_access(input int after_cycles);
    @(negedge clk);
    present(1'b0, 1'b0, 1'b0, 18'h10, 32'd0);
    @(negedge clk);
    set_valid(1'b0);
    repeat (after_cycles) @(negedge clk);
    check("mid_strobe", 32'(o_mem_read), 32'd1);
    set_rst(1'b1);
    @(negedge clk);
    set_rst(1'b0);
    check_reset_state();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_resp_after_rst", 32'(o_resp_valid | o_mem_read | o_mem_write), 32'd0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    resp_ready_a = 1'b0; resp_ready_b = 1'b0;
    req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
    req_addr = 18'd0; req_wdata = 32'd0;
    sel_b = 1'b0;
    repeat (3) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    sel_b = 1'b0; check_reset_state();
    sel_b = 1'b1; check_reset_state();

    // WAIT_CYCLES = 1
    sel_b = 1'b0;
    do_req(1, 0, 0, 18'h10,    32'hDEADBEEF, 32'h00000000, 0, 0);
    do_req(0, 0, 0, 18'h10,    32'h0,        32'hDEADBEEF, 0, 0);
    do_req(0, 1, 1, 18'h13,    32'h0,        32'hFFFFFFDE, 0, 0);
    do_req(0, 1, 0, 18'h13,    32'h0,        32'h000000DE, 0, 0);
    do_req(0, 0, 0, 18'd125,   32'h0,        32'h00000000, 1, 0);
    do_req(1, 0, 0, 18'd124,   32'h11223344, 32'h00000000, 0, 0);
    do_req(1, 1, 0, 18'd127,   32'h12345680, 32'h00000000, 0, 0);
    do_req(0, 1, 1, 18'd127,   32'h0,        32'hFFFFFF80, 0, 0);
    do_req(0, 1, 0, 18'd127,   32'h0,        32'h00000080, 0, 0);
    do_req(0, 0, 0, 18'd124,   32'h0,        32'h80223344, 0, 0);
    do_req(0, 1, 0, 18'd128,   32'h0,        32'h00000000, 1, 0);
    do_req(1, 1, 0, 18'h11,    32'hFFFFFF55, 32'h00000000, 0, 0);
    do_req(0, 0, 0, 18'h10,    32'h0,        32'hDEAD55EF, 0, 5);
    do_req(0, 0, 0, 18'h3FFFF, 32'h0,        32'h00000000, 1, 0);
    do_req(1, 1, 0, 18'h3FFFF, 32'h000000AA, 32'h00000000, 1, 2);
    reset_mid_access(0);
    do_req(0, 0, 0, 18'h10,    32'h0,        32'hDEAD55EF, 0, 0);

    // WAIT_CYCLES = 3
    sel_b = 1'b1;
    do_req(1, 0, 0, 18'h20,    32'hCAFEF00D, 32'h00000000, 0, 0);
    do_req(0, 0, 0, 18'h20,    32'h0,        32'hCAFEF00D, 0, 0);
    do_req(0, 1, 1, 18'h22,    32'h0,        32'hFFFFFFFE, 0, 0);
    do_req(0, 1, 0, 18'h20,    32'h0,        32'h0000000D, 0, 3);
    do_req(0, 0, 0, 18'd126,   32'h0,        32'h00000000, 1, 0);
    reset_mid_access(1);
    do_req(0, 0, 0, 18'h20,    32'h0,        32'hCAFEF00D, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
